// File: rtl/dht11_pkg.sv
// DHT11 single-wire protocol constants shared by the responder and the reader.
// No logic: encodings, timing in microseconds, frame layout.
// No flow control: pure definitions.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_LOW  = 3'd1,
    ST_RESP_DELAY = 3'd2,
    ST_RESP_LOW   = 3'd3,
    ST_RESP_HIGH  = 3'd4,
    ST_BIT_LOW    = 3'd5,
    ST_BIT_HIGH   = 3'd6,
    ST_END_LOW    = 3'd7
  } dht11_state_e;

  localparam int RESP_LOW_US  = 80;
  localparam int RESP_HIGH_US = 80;
  localparam int BIT_LOW_US   = 50;
  localparam int BIT0_HIGH_US = 26;
  localparam int BIT1_HIGH_US = 70;
  localparam int END_LOW_US   = 50;
  localparam int FRAME_BITS   = 40;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
  } dht11_meas_t;

  // Wire frame: four measurement bytes MSB-first followed by their 8-bit sum.
  function automatic logic [FRAME_BITS-1:0] dht11_frame(input dht11_meas_t m);
    logic [7:0] cs;
    cs = m.hum_int + m.hum_dec + m.temp_int + m.temp_dec;
    return {m, cs};
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler: one-cycle tick every CLK_FREQ_HZ/1e6 clocks.
// Latency: tick is registered; first tick one divider period after reset.
// No backpressure: free-running.
module us_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Wrap the divider and flag the wrap cycle.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with response + 40-bit frame.
// Latency: drive begins RESP_DELAY_US after host release; outputs registered.
// No backpressure: host timing is not checked once the response has started.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht11_i,
  output logic       dht11_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state
);

  logic                  tick;
  logic                  sync1_q, sync2_q;
  dht11_state_e          state_q, state_d;
  logic [15:0]           us_cnt_q, us_cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  drive_q, drive_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           dur_lim;
  logic                  dur_done;
  logic [16:0]           start_len;
  logic                  start_ok;
  logic                  line_s;
  dht11_meas_t           meas;

  us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  assign line_s    = sync2_q;
  assign meas      = {hum_int, hum_dec, temp_int, temp_dec};
  // Counter started at 0 one cycle after the low level was first seen.
  assign start_len = {1'b0, us_cnt_q} + 17'd1;
  assign start_ok  = start_len >= 17'(START_MIN_US);

  // Duration of the current timed state; BIT_HIGH length follows the current MSB.
  always_comb begin
    dur_lim = '0;
    case (state_q)
      ST_RESP_DELAY: dur_lim = 16'(RESP_DELAY_US);
      ST_RESP_LOW:   dur_lim = 16'(RESP_LOW_US);
      ST_RESP_HIGH:  dur_lim = 16'(RESP_HIGH_US);
      ST_BIT_LOW:    dur_lim = 16'(BIT_LOW_US);
      ST_BIT_HIGH:   dur_lim = frame_q[FRAME_BITS-1] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      ST_END_LOW:    dur_lim = 16'(END_LOW_US);
      default:       dur_lim = '0;
    endcase
    dur_done = tick && (us_cnt_q == dur_lim - 16'd1);
  end

  // Next-state, frame shift and bit counting.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    case (state_q)
      ST_IDLE:       if (!line_s) state_d = ST_START_LOW;
      ST_START_LOW: begin
        if (line_s) begin
          if (start_ok) begin
            state_d   = ST_RESP_DELAY;
            frame_d   = dht11_frame(meas);
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_DELAY: if (dur_done) state_d = ST_RESP_LOW;
      ST_RESP_LOW:   if (dur_done) state_d = ST_RESP_HIGH;
      ST_RESP_HIGH:  if (dur_done) state_d = ST_BIT_LOW;
      ST_BIT_LOW:    if (dur_done) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (dur_done) begin
          if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
            state_d = ST_END_LOW;
          end else begin
            state_d   = ST_BIT_LOW;
            bit_cnt_d = bit_cnt_q + 6'd1;
            frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      ST_END_LOW:    if (dur_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // Durations restart at every state entry; saturate so long starts stay valid.
    us_cnt_d = us_cnt_q;
    if (state_d != state_q)                 us_cnt_d = '0;
    else if (tick && us_cnt_q != 16'hFFFF)  us_cnt_d = us_cnt_q + 16'd1;

    // Outputs computed from the next state so the registers line up with state_q.
    drive_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_START_LOW);
    done_d  = (state_q == ST_END_LOW) && (state_d == ST_IDLE);
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      us_cnt_q  <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= dht11_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      us_cnt_q  <= us_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dht11_drive_low = drive_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign state           = 3'(state_q);

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder at 1 MHz (one clock = one microsecond).
// Each transaction records drive_low run lengths and compares them with the
// pulse train computed from the bytes and the DHT11 timing rules.
module tb_dht11_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dht11_i = 1'b1;
  logic       drv, busy, frame_done;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic [2:0] state;

  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_FREQ_HZ   (1_000_000),
    .START_MIN_US  (100),
    .RESP_DELAY_US (30)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dht11_i         (dht11_i),
    .dht11_drive_low (drv),
    .hum_int         (hum_int),
    .hum_dec         (hum_dec),
    .temp_int        (temp_int),
    .temp_dec        (temp_dec),
    .busy            (busy),
    .frame_done      (frame_done),
    .state           (state)
  );

  typedef struct {
    logic [7:0] hi, hd, ti, td;
    int         low_len;
    bit         exp_frame;
    logic [7:0] exp_cs;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  int runs[$];
  int exp_runs[$];
  int fd_cnt;
  bit busy_bad;
  bit saw_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host start pulse of low_len us, then record drive_low runs from the first low.
  // When the low-run count reaches chg_at, temp_int is overwritten with chg_val.
  task automatic xfer(input int low_len, input int chg_at, input logic [7:0] chg_val, input int budget);
    int  cur, lows, tail;
    bit  started;
    logic last;
    runs = {};
    fd_cnt = 0; busy_bad = 0; saw_busy = 0;
    cur = 0; lows = 0; tail = 0; started = 0; last = 1'b0;
    @(posedge clk); #1 dht11_i = 1'b0;
    repeat (low_len) @(posedge clk);
    #1 dht11_i = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (drv && !busy) busy_bad = 1;
      if (busy) saw_busy = 1;
      if (!started) begin
        if (drv) begin started = 1; last = 1'b1; cur = 1; lows = 1; end
      end else if (drv == last) begin
        cur++;
      end else begin
        runs.push_back(cur);
        last = drv; cur = 1;
        if (drv) begin
          lows++;
          if (lows == chg_at) temp_int = chg_val;
        end
      end
      if (fd_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
    end
    if (started && last) runs.push_back(cur);
  endtask

  // Pulse train for a frame: response 80/80, per bit 50 low + 26/70 high, 50 low tail.
  task automatic model(input logic [7:0] hi, hd, ti, td, output logic [39:0] f);
    int s;
    s = (int'(hi) + int'(hd) + int'(ti) + int'(td)) % 256;
    f = {hi, hd, ti, td, 8'(s)};
    exp_runs = {80, 80};
    for (int i = 39; i >= 0; i--) begin
      exp_runs.push_back(50);
      exp_runs.push_back(f[i] ? 70 : 26);
    end
    exp_runs.push_back(50);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] hi, hd, ti, td, input logic [7:0] exp_cs);
    logic [39:0] f, dec;
    int first;
    model(hi, hd, ti, td, f);
    check({tag, " run count"}, runs.size(), exp_runs.size());
    first = -1;
    for (int i = 0; i < runs.size() && i < exp_runs.size(); i++)
      if (runs[i] != exp_runs[i] && first < 0) first = i;
    check({tag, " first bad run index"}, first, -1);
    dec = '0;
    if (runs.size() == 83)
      for (int i = 0; i < 40; i++) dec = {dec[38:0], runs[3 + 2*i] > 48};
    check({tag, " decoded frame"}, dec, f);
    check({tag, " checksum"}, dec[7:0], exp_cs);
    check({tag, " frame_done pulses"}, fd_cnt, 1);
    check({tag, " drive without busy"}, busy_bad, 0);
    check({tag, " busy after frame"}, busy, 0);
    check({tag, " state after frame"}, state, 0);
  endtask

  task automatic check_ignored(input string tag);
    check({tag, " drive runs"}, runs.size(), 0);
    check({tag, " busy seen"}, saw_busy, 0);
    check({tag, " frame_done pulses"}, fd_cnt, 0);
    check({tag, " state"}, state, 0);
  endtask

  initial begin
    vec_t tbl[7];
    int lows, fd, drove, ll;
    logic prev;
    logic [7:0] b0, b1, b2, b3;
    int s;

    tbl[0] = '{8'h37, 8'h00, 8'h19, 8'h00, 150,  1'b1, 8'h50};
    tbl[1] = '{8'h37, 8'h00, 8'h19, 8'h00, 60,   1'b0, 8'h00};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 150,  1'b1, 8'hFC};
    tbl[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 100,  1'b1, 8'h14};
    tbl[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 99,   1'b0, 8'h00};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1000, 1'b1, 8'h00};
    tbl[6] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 3,    1'b0, 8'h00};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset drive_low", drv, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset state", state, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      hum_int = tbl[i].hi; hum_dec = tbl[i].hd; temp_int = tbl[i].ti; temp_dec = tbl[i].td;
      xfer(tbl[i].low_len, 0, 8'h00, tbl[i].exp_frame ? 6000 : 300);
      if (tbl[i].exp_frame)
        check_frame($sformatf("vec%0d", i), tbl[i].hi, tbl[i].hd, tbl[i].ti, tbl[i].td, tbl[i].exp_cs);
      else
        check_ignored($sformatf("vec%0d", i));
      repeat (3) @(posedge clk);
    end

    // Byte change during bit 5 (seventh low run) must not reach the wire.
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    xfer(150, 7, 8'h20, 6000);
    check_frame("inflight change", 8'h37, 8'h00, 8'h19, 8'h00, 8'h50);
    check("inflight change applied", temp_int, 8'h20);
    temp_int = 8'h19;

    // Reset during bit 12 aborts the frame; next start is served in full.
    @(posedge clk); #1 dht11_i = 1'b0;
    repeat (150) @(posedge clk);
    #1 dht11_i = 1'b1;
    lows = 0; prev = 1'b0;
    for (int c = 0; c < 3000 && lows < 14; c++) begin
      @(negedge clk);
      if (drv && !prev) lows++;
      prev = drv;
    end
    check("reset test reached bit 12", lows, 14);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mid-frame reset drive_low", drv, 0);
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset frame_done", frame_done, 0);
    check("mid-frame reset state", state, 0);
    rst = 1'b0;
    fd = 0; drove = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done) fd++;
      if (drv) drove++;
    end
    check("after reset frame_done", fd, 0);
    check("after reset drive cycles", drove, 0);
    xfer(150, 0, 8'h00, 6000);
    check_frame("post reset", 8'h37, 8'h00, 8'h19, 8'h00, 8'h50);

    // Random bytes and start widths; accepted iff the host held low >= 100 us.
    for (int r = 0; r < 6; r++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      ll = int'($urandom_range(40, 200));
      hum_int = b0; hum_dec = b1; temp_int = b2; temp_dec = b3;
      s = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
      xfer(ll, 0, 8'h00, (ll >= 100) ? 6000 : 300);
      if (ll >= 100) check_frame($sformatf("rand%0d", r), b0, b1, b2, b3, 8'(s));
      else           check_ignored($sformatf("rand%0d", r));
      repeat (3) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter START_MIN_US, default 18000, minimum host start-low width accepted.
REQ-003 SHALL have parameter RESP_DELAY_US, default 30, gap between host release and responder drive.
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dht11_i  input  1  sampled single-wire line level (asynchronous).
REQ-007 SHALL have port dht11_drive_low  output  1  1 = pull line low; 0 = release (open-drain, tristate at top level).
REQ-008 SHALL have ports hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to transmit.
REQ-009 SHALL have port busy  output  1  high from start acceptance until frame end.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when the frame completes.
REQ-011 SHALL have port state  output  3  current FSM state encoding, for debug.

Function
REQ-012 SHALL pass dht11_i through a 2-flop synchronizer; all decisions use the synchronized level.
REQ-013 SHALL derive a 1 us tick from a prescaler of CLK_FREQ_HZ/1_000_000 cycles; all durations are counted in ticks by a 16-bit us counter cleared on each state entry.
REQ-014 SHALL implement states IDLE(0), START_LOW(1), RESP_DELAY(2), RESP_LOW(3), RESP_HIGH(4), BIT_LOW(5), BIT_HIGH(6), END_LOW(7).
REQ-015 IDLE: line low -> START_LOW.
REQ-016 START_LOW: line high before START_MIN_US -> IDLE (glitch/short pulse ignored); line high after >= START_MIN_US -> RESP_DELAY, latch frame, assert busy.
REQ-017 Latched frame SHALL be 40 bits, MSB-first: hum_int, hum_dec, temp_int, temp_dec, checksum = 8-bit sum of the four bytes modulo 256.
REQ-018 RESP_DELAY: released for RESP_DELAY_US, then RESP_LOW.
REQ-019 RESP_LOW: drive low 80 us; RESP_HIGH: release 80 us.
REQ-020 Per bit: BIT_LOW drive low 50 us; BIT_HIGH release 26 us for 0, 70 us for 1; 6-bit bit counter 0..39.
REQ-021 After bit 39 BIT_HIGH -> END_LOW: drive low 50 us, then release, pulse frame_done, deassert busy, -> IDLE, all in the same cycle.
REQ-022 dht11_drive_low SHALL be 1 only in RESP_LOW, BIT_LOW, END_LOW, registered, no glitches.
REQ-023 Input bytes changing while busy SHALL not alter the frame in flight.
REQ-024 Line level SHALL be ignored from RESP_DELAY through END_LOW (no contention detection).
REQ-025 After IDLE re-entry a new start SHALL be accepted immediately.

Reset
REQ-026 On rst: state=IDLE, dht11_drive_low=0, busy=0, frame_done=0, counters, prescaler and latched frame cleared, synchronizer flops set to 1 (idle-high line).
REQ-027 rst asserted mid-frame SHALL release the line on the next clock edge and abort the frame with no frame_done pulse.

Structure
REQ-028 Package dht11_pkg SHALL hold state encodings, timing constants (80, 50, 26, 70 us), frame width 40; shared with the DHT11 reader.
REQ-029 Sub-module us_tick_gen (prescaler, parameter CLK_FREQ_HZ, output one-cycle tick) SHALL be used.

Verification (CLK_FREQ_HZ=1_000_000, START_MIN_US=100)
REQ-030 Bytes 0x37,0x00,0x19,0x00; host low 150 us then release -> low 80/high 80, 40 bits decode to 0x37001900 plus checksum 0x50, frame_done once.
REQ-031 Host low 60 us then release -> no drive, busy stays 0, state returns to IDLE.
REQ-032 Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC; every data bit high 70 us except last two checksum bits at 26 us.
REQ-033 rst pulse during bit 12 -> dht11_drive_low=0 next cycle, busy=0, no frame_done; next start yields full correct frame.
REQ-034 Change temp_int 0x19->0x20 during bit 5 -> transmitted frame still carries 0x19 and checksum 0x50.
REQ-035 Loopback with DHT11 reader: reader temp/hum outputs equal responder inputs, reader valid asserted.
